// File: rtl/hex_display_ctrl_pkg.sv
// hex_display_ctrl_pkg: shared state encoding, blank code and active-low 7-segment glyph table.
package hex_display_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
endpackage

// File: rtl/hex_display_ctrl_seg7_lut.sv
// seg7_lut: combinational hex nibble to active-low {g,f,e,d,c,b,a} glyph.
module seg7_lut
  import hex_display_ctrl_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = GLYPH[nib_i];
endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: scans a captured hex value MSD-first through one shared decoder into
// per-digit segment registers, with leading-zero blanking, per-digit enable and blinking.
module hex_display_ctrl
  import hex_display_ctrl_pkg::*;
#(
  parameter int NDIG      = 6,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*NDIG-1:0]   value,
  input  logic                blank_lz,
  input  logic [NDIG-1:0]     en_mask,
  input  logic [NDIG-1:0]     blink_mask,
  output logic                busy,
  output logic                done,
  output logic [7*NDIG-1:0]   hex_o
);
  localparam int IW = $clog2(NDIG);
  localparam int CW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] IDX_TOP = IW'(NDIG - 1);
  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   seen_q, seen_d;
  logic [NDIG-1:0][3:0]   val_q, val_d;
  logic                   blz_q, blz_d;
  logic [NDIG-1:0]        en_q, en_d, blink_q, blink_d;
  logic [NDIG-1:0][6:0]   dig_q, dig_d;
  logic [CW-1:0]          cnt_q;
  logic                   phase_q;
  logic [3:0]             nib;
  logic [6:0]             seg;
  logic                   blank;
  seg7_lut u_lut (.nib_i(nib), .seg_o(seg));
  assign nib   = val_q[idx_q];
  assign blank = !en_q[idx_q] | (blz_q & (nib == 4'd0) & !seen_q & (idx_q != '0));
  assign busy  = state_q == SCAN;
  assign done  = state_q == DONE;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seen_d  = seen_q;
    val_d   = val_q;
    blz_d   = blz_q;
    en_d    = en_q;
    blink_d = blink_q;
    dig_d   = dig_q;
    if (state_q == SCAN) begin
      dig_d[idx_q] = blank ? SEG_BLANK : seg;
      seen_d       = seen_q | (|nib);
      idx_d        = idx_q - 1'b1;
      state_d      = idx_q == '0 ? DONE : SCAN;
    end else if (load) begin
      val_d   = value;
      blz_d   = blank_lz;
      en_d    = en_mask;
      blink_d = blink_mask;
      idx_d   = IDX_TOP;
      seen_d  = 1'b0;
      state_d = SCAN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      seen_q  <= 1'b0;
      val_q   <= '0;
      blz_q   <= 1'b0;
      en_q    <= '0;
      blink_q <= '0;
      dig_q   <= {NDIG{SEG_BLANK}};
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seen_q  <= seen_d;
      val_q   <= val_d;
      blz_q   <= blz_d;
      en_q    <= en_d;
      blink_q <= blink_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_q == CNT_LAST ? '0 : cnt_q + 1'b1;
      phase_q <= phase_q ^ (cnt_q == CNT_LAST);
    end
  end
  // blink gating sits after the digit registers so a scan never disturbs the blink cadence
  for (genvar g = 0; g < NDIG; g++) begin : g_out
    assign hex_o[7*g +: 7] = (phase_q & blink_q[g]) ? SEG_BLANK : dig_q[g];
  end
endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb_hex_display_ctrl: scoreboard bench; expected displays are queued at each accepted load
// and a negedge monitor compares them when done pulses and on every idle cycle.
module tb_hex_display_ctrl;
  localparam int NDIG = 6;
  localparam int BLINK_DIV = 4;
  localparam logic [6:0] GL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  typedef struct packed {
    logic [7*NDIG-1:0] hex;
    logic [NDIG-1:0]   bl;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b0;
  logic [4*NDIG-1:0] value = '0;
  logic blank_lz = 1'b0;
  logic [NDIG-1:0] en_mask = '0;
  logic [NDIG-1:0] blink_mask = '0;
  logic busy, done;
  logic [7*NDIG-1:0] hex_o;
  int checks = 0;
  int failures = 0;
  int ticks = 0;
  int run = 0;
  exp_t sb[$];
  logic [7*NDIG-1:0] disp = '1;
  logic [NDIG-1:0] disp_bl = '0;
  hex_display_ctrl #(.NDIG(NDIG), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .blank_lz(blank_lz),
    .en_mask(en_mask), .blink_mask(blink_mask), .busy(busy), .done(done), .hex_o(hex_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) ticks <= rst ? 0 : ticks + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [7*NDIG-1:0] model(input logic [4*NDIG-1:0] v, input logic blz,
                                               input logic [NDIG-1:0] en);
    logic [7*NDIG-1:0] r;
    logic lead;
    r = '1;
    for (int i = 0; i < NDIG; i++) begin
      lead = blz && (i != 0) && ((v >> (4*i)) == 0);
      r[7*i +: 7] = (!en[i] || lead) ? 7'h7F : GL[v[4*i +: 4]];
    end
    return r;
  endfunction
  function automatic logic [7*NDIG-1:0] shown(input logic [7*NDIG-1:0] d, input logic [NDIG-1:0] bl);
    logic [7*NDIG-1:0] r;
    logic ph;
    ph = ((ticks / BLINK_DIV) % 2) == 1;
    for (int i = 0; i < NDIG; i++) r[7*i +: 7] = (ph && bl[i]) ? 7'h7F : d[7*i +: 7];
    return r;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      disp = '1;
      disp_bl = '0;
      run = 0;
    end else begin
      if (busy) run++;
      if (done) begin
        chk("busy_in_done", {63'd0, busy}, 64'd0);
        chk("scan_len", 64'(run), 64'(NDIG));
        run = 0;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done act=1 exp=0 t=%0t", $time);
        end else begin
          e = sb.pop_front();
          disp = e.hex;
          disp_bl = e.bl;
        end
      end
      if (!busy) chk("hex_o", 64'(hex_o), 64'(shown(disp, disp_bl)));
    end
  end
  task automatic load_go(input logic [4*NDIG-1:0] v, input logic blz,
                         input logic [NDIG-1:0] en, input logic [NDIG-1:0] bl);
    value = v;
    blank_lz = blz;
    en_mask = en;
    blink_mask = bl;
    load = 1'b1;
    sb.push_back('{hex: model(v, blz, en), bl: bl});
    @(negedge clk);
    load = 1'b0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) return;
    end
    checks++;
    failures++;
    $display("FAIL done_timeout act=0 exp=1 t=%0t", $time);
  endtask
  initial begin
    logic [4*NDIG-1:0] v;
    repeat (2) @(negedge clk);
    chk("rst_hex", 64'(hex_o), 64'(42'h3FF_FFFF_FFFF));
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    load_go(24'h0012AF, 1'b0, 6'h3F, 6'h00);
    wait_done();
    chk("plan_digits", 64'(hex_o),
        64'({7'b1000000, 7'b1000000, 7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}));
    @(negedge clk);
    load_go(24'h0012AF, 1'b1, 6'h3F, 6'h00);
    wait_done();
    chk("plan_lz", 64'(hex_o[41:28]), 64'(14'h3FFF));
    @(negedge clk);
    load_go(24'h000000, 1'b1, 6'h3F, 6'h00);
    wait_done();
    chk("plan_zero", 64'(hex_o), 64'({35'h7_FFFF_FFFF, 7'b1000000}));
    @(negedge clk);
    load_go(24'h000008, 1'b0, 6'b111110, 6'h00);
    repeat (2) @(negedge clk);
    value = 24'hFFFFFF;
    en_mask = 6'h3F;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_done();
    load_go(24'h00ABCD, 1'b1, 6'h3F, 6'h00);
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    wait_done();
    @(negedge clk);
    load_go(24'h000003, 1'b0, 6'h3F, 6'b000001);
    wait_done();
    repeat (12) @(negedge clk);
    load_go(24'h987654, 1'b0, 6'h3F, 6'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_hex", 64'(hex_o), 64'(42'h3FF_FFFF_FFFF));
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_nodone", {63'd0, done}, 64'd0);
    end
    for (int n = 0; n < 30; n++) begin
      v = 24'($urandom) >> (4 * $urandom_range(0, NDIG));
      load_go(v, 1'($urandom), ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h3F,
              ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00);
      wait_done();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Sequencer that drives an NDIG-digit bank of active-low 7-segment displays from one shared hex-to-segment lookup. On a load strobe it captures a packed hex value and control masks. It then walks the digits most-significant first, one per cycle, through the single decoder instance, and latches each result into a per-digit segment register. It adds leading-zero blanking, per-digit enable and per-digit blinking, and sits between arithmetic/counter datapaths and the board's HEX outputs.

## Interface
- NDIG, 6, number of digits (≥2)
- BLINK_DIV, 25_000_000, clock cycles per blink half-period (≥1)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- load  in  1  capture request; accepted only when busy=0
- value  in  4*NDIG  packed nibbles; digit i = value[4i+3:4i], digit 0 least significant
- blank_lz  in  1  enable leading-zero blanking
- en_mask  in  NDIG  per-digit enable; 0 forces digit dark
- blink_mask  in  NDIG  per-digit blink enable
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse: all digit registers updated
- hex_o  out  7*NDIG  digit i segments = hex_o[7i+6:7i], active-low, bit order {g,f,e,d,c,b,a}

## Operation
- States: IDLE, SCAN, DONE.
- IDLE/DONE with load=1: capture value, blank_lz, en_mask and blink_mask into shadow registers. Set idx=NDIG-1, clear seen_nz, go to SCAN.
- SCAN, each cycle: nib = shadow nibble[idx], seg = lut(nib).
  - Blank condition: (!en[idx]) or (blank_lz and nib==0 and !seen_nz and idx!=0).
  - digit_reg[idx] <= blank ? 7'h7F : seg.
  - seen_nz <= seen_nz | (nib!=0), regardless of enable.
  - idx==0: go to DONE; otherwise idx decrements.
- DONE: lasts one cycle, then IDLE unless load is accepted, in which case go directly to SCAN.
- load while busy=1 is ignored. It is not queued.
- Digit 0 is never leading-zero blanked, so value 0 shows "0" on digit 0.
- Blink:
  - A free-running counter 0..BLINK_DIV-1 toggles phase at wrap.
  - hex_o digit i = (phase & blink_sh[i]) ? 7'h7F : digit_reg[i]. This path is combinational from registers only.
- Digit registers hold their value indefinitely between scans.
- Glyphs (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110

## Timing
- Reset values: state IDLE, busy 0, done 0, every digit_reg 7'h7F, shadow registers 0, blink counter 0, phase 0. As a result, every hex_o digit reads 7'h7F.
- Load accepted at edge E0: busy=1 from E0 through E_NDIG.
- digit NDIG-1 updates at E1 and digit 0 at E_NDIG.
- done=1 for exactly the one cycle after E_NDIG, with busy=0 in that cycle.
- Scan latency is NDIG cycles from load to last digit update.
- Back-to-back: load asserted in the done cycle restarts the scan with no IDLE gap.
- rst mid-scan: the next edge forces reset values. The partial update is discarded and digits go dark.
- Blink phase is independent of load and scan and is not resynchronised by them.

## Structure
- Shared package holds:
  - state enum {IDLE, SCAN, DONE}
  - constant SEG_BLANK = 7'h7F
  - glyph constants
- One sub-module, seg7_lut: purely combinational 4-bit nibble to 7-bit active-low glyph, using the table above. It is instantiated once, shared across all digits.
- Controller holds the FSM, idx counter, seen_nz, shadow registers, digit register array and blink divider.

## Test plan
(NDIG=6, BLINK_DIV=4)
- Reset: assert rst 2 cycles -> every hex_o digit = 7'h7F, busy=0, done=0.
- Load value=24'h0012AF, blank_lz=0, en=6'h3F, blink=0 -> busy high 6 cycles, then done high 1 cycle.
  - Digits 5..0 = 1000000, 1000000, 1111001, 0100100, 0001000, 0001110.
- Same value with blank_lz=1 -> digits 5,4 = 7'h7F, rest as above.
  - value=0 with blank_lz=1 -> digits 5..1 dark, digit 0 = 1000000.
- en_mask=6'b111110, value=24'h000008 -> digit 0 dark.
  - Load pulsed on the 3rd busy cycle -> ignored; register contents match the first load.
  - Load in the done cycle -> busy re-asserts next cycle.
- blink_mask=6'b000001 after a scan of value 24'h000003 -> digit 0 alternates 0110000 / 7'h7F every 4 cycles, other digits steady.
- rst asserted during the 3rd SCAN cycle -> next cycle all digits 7'h7F, busy=0, and no done pulse.
